// File: rtl/deserializer.sv
// deserializer
//   Collects an LSB-first serial bit stream into WIDTH-bit words. Each
//   completed word is presented on a registered output with a valid/ready
//   handshake.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   datain    in   serial data bit
//   validIn   in   datain carries a valid bit this cycle
//   clear     in   synchronous abort of the partial word (output stage untouched)
//   ready     in   consumer accepts dataout this cycle
//   dataout   out  assembled word, first received bit in dataout[0]
//   validOut  out  dataout holds an unaccepted word
//   overrun   out  one-cycle pulse: a completed word was dropped
//   busy      out  a partial word is in progress
module deserializer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             datain,
   input  logic             validIn,
   input  logic             clear,
   input  logic             ready,
   output logic [WIDTH-1:0] dataout,
   output logic             validOut,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] word;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_next;
   logic             capture;
   logic             complete;

   // A bit presented together with clear is discarded along with the partial word.
   assign capture  = validIn & ~clear;
   assign complete = capture & (cnt == LAST);

   // Shift register with the incoming bit merged in at position cnt. On the
   // completing edge this is exactly {datain, shreg[WIDTH-2:0]}.
   always_comb begin
      word      = shreg;
      word[cnt] = datain;
   end

   always_comb begin
      cnt_next = cnt;
      if (clear) begin
         cnt_next = '0;
      end else if (validIn) begin
         cnt_next = complete ? '0 : cnt + CW'(1);
      end
   end

   // Input stage: bit counter, shift register, busy flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         shreg <= '0;
         busy  <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         busy <= (cnt_next != '0);
         if (capture) begin
            shreg <= word;
         end
      end
   end

   // Output stage: one-word holding register with handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         dataout <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         case (state)
            EMPTY: begin
               if (complete) begin
                  dataout <= word;
                  state   <= FULL;
               end
            end
            FULL: begin
               if (complete) begin
                  // Accept and reload on the same edge keeps validOut high
                  // with no bubble; without ready the new word is lost.
                  if (ready) begin
                     dataout <= word;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else if (ready) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign validOut = (state == FULL);

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

   logic        clk;
   logic        rst_n;
   logic        datain;
   logic        validIn;
   logic        clear;
   logic        ready;
   logic [31:0] dataout;
   logic        validOut;
   logic        overrun;
   logic        busy;

   int nvec;
   int nerr;

   deserializer #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .datain   (datain),
      .validIn  (validIn),
      .clear    (clear),
      .ready    (ready),
      .dataout  (dataout),
      .validOut (validOut),
      .overrun  (overrun),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs for one clock, then sample 1 time unit after the edge.
   task automatic cycle(input logic d, input logic v, input logic c, input logic r);
      datain  = d;
      validIn = v;
      clear   = c;
      ready   = r;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n, input logic r);
      for (int i = 0; i < n; i++) cycle(w[i], 1'b1, 1'b0, r);
   endtask

   task automatic test_reset;
      logic [31:0] w;
      rst_n = 1'b1;
      datain = 1'b0; validIn = 1'b0; clear = 1'b0; ready = 1'b0;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         nvec++;
         if ({dataout, validOut, overrun, busy} !== 35'd0) begin
            nerr++;
            $display("FAIL reset_hold: got data=%h v=%b o=%b b=%b want all 0", dataout, validOut, overrun, busy);
         end
      end
      rst_n = 1'b1;
      // 17 bits of a word, then an asynchronous reset mid-word
      w = 32'hFFFF_FFFF;
      send_bits(w, 17, 1'b0);
      nvec++;
      if (busy !== 1'b1) begin
         nerr++;
         $display("FAIL reset_busy_mid: got %b want 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      nvec++;
      if ({busy, validOut} !== 2'b00) begin
         nerr++;
         $display("FAIL reset_async: got busy=%b v=%b want 0 0", busy, validOut);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      w = 32'h600D_F00D;
      send_bits(w, 32, 1'b1);
      nvec++;
      if (validOut !== 1'b1 || dataout !== 32'h600D_F00D) begin
         nerr++;
         $display("FAIL reset_new_word: got v=%b data=%h want 1 600df00d", validOut, dataout);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      nvec++;
      if (validOut !== 1'b0) begin
         nerr++;
         $display("FAIL reset_drain: got %b want 0", validOut);
      end
   endtask

   task automatic test_contiguous;
      logic [31:0] w;
      w = 32'hA5A5_3C0F;
      for (int i = 0; i < 32; i++) begin
         cycle(w[i], 1'b1, 1'b0, 1'b1);
         nvec++;
         if (busy !== (i != 31)) begin
            nerr++;
            $display("FAIL contig_busy bit %0d: got %b want %b", i, busy, (i != 31));
         end
         if (i < 31) begin
            nvec++;
            if (validOut !== 1'b0) begin
               nerr++;
               $display("FAIL contig_early_valid bit %0d: got %b want 0", i, validOut);
            end
         end
      end
      nvec++;
      if (validOut !== 1'b1 || dataout !== 32'hA5A5_3C0F) begin
         nerr++;
         $display("FAIL contig_word: got v=%b data=%h want 1 a5a53c0f", validOut, dataout);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      nvec++;
      if (validOut !== 1'b0 || dataout !== 32'hA5A5_3C0F) begin
         nerr++;
         $display("FAIL contig_after: got v=%b data=%h want 0 a5a53c0f", validOut, dataout);
      end
   endtask

   task automatic test_gaps;
      logic [31:0] w;
      logic        vseen;
      w = 32'h1234_5678;
      vseen = 1'b0;
      for (int i = 0; i < 32; i++) begin
         cycle(w[i], 1'b1, 1'b0, 1'b1);
         if (i == 31) break;
         if (validOut) vseen = 1'b1;
         // gap cycles present the opposite bit value, which must be ignored
         cycle(~w[i], 1'b0, 1'b0, 1'b1);
         if (validOut) vseen = 1'b1;
         cycle(~w[i], 1'b0, 1'b0, 1'b1);
         if (validOut) vseen = 1'b1;
      end
      nvec++;
      if (vseen !== 1'b0) begin
         nerr++;
         $display("FAIL gaps_early_valid: got %b want 0", vseen);
      end
      nvec++;
      if (validOut !== 1'b1 || dataout !== 32'h1234_5678) begin
         nerr++;
         $display("FAIL gaps_word: got v=%b data=%h want 1 12345678", validOut, dataout);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      nvec++;
      if (validOut !== 1'b0) begin
         nerr++;
         $display("FAIL gaps_after: got %b want 0", validOut);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] w;
      int          vcount;
      int          ocount;
      w = 32'hFFFF_FFFF;
      send_bits(w, 32, 1'b1);
      nvec++;
      if (validOut !== 1'b1 || dataout !== 32'hFFFF_FFFF) begin
         nerr++;
         $display("FAIL b2b_word1: got v=%b data=%h want 1 ffffffff", validOut, dataout);
      end
      w = 32'h0000_0001;
      vcount = 0;
      ocount = 0;
      for (int i = 0; i < 31; i++) begin
         cycle(w[i], 1'b1, 1'b0, 1'b1);
         if (validOut) vcount++;
         if (overrun) ocount++;
      end
      nvec++;
      if (vcount != 0) begin
         nerr++;
         $display("FAIL b2b_pulse_width: got %0d extra valid cycles want 0", vcount);
      end
      cycle(w[31], 1'b1, 1'b0, 1'b1);
      if (overrun) ocount++;
      nvec++;
      if (validOut !== 1'b1 || dataout !== 32'h0000_0001) begin
         nerr++;
         $display("FAIL b2b_word2: got v=%b data=%h want 1 00000001", validOut, dataout);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (overrun) ocount++;
      nvec++;
      if (ocount != 0 || validOut !== 1'b0) begin
         nerr++;
         $display("FAIL b2b_overrun: got overruns=%0d v=%b want 0 0", ocount, validOut);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] w;
      int          ocount;
      w = 32'hDEAD_BEEF;
      send_bits(w, 32, 1'b0);
      nvec++;
      if (validOut !== 1'b1 || dataout !== 32'hDEAD_BEEF) begin
         nerr++;
         $display("FAIL bp_word1: got v=%b data=%h want 1 deadbeef", validOut, dataout);
      end
      w = 32'hCAFE_F00D;
      ocount = 0;
      for (int i = 0; i < 31; i++) begin
         cycle(w[i], 1'b1, 1'b0, 1'b0);
         if (overrun) ocount++;
      end
      nvec++;
      if (ocount != 0 || validOut !== 1'b1) begin
         nerr++;
         $display("FAIL bp_hold: got overruns=%0d v=%b want 0 1", ocount, validOut);
      end
      cycle(w[31], 1'b1, 1'b0, 1'b0);
      nvec++;
      if (overrun !== 1'b1 || validOut !== 1'b1 || dataout !== 32'hDEAD_BEEF) begin
         nerr++;
         $display("FAIL bp_overrun: got o=%b v=%b data=%h want 1 1 deadbeef", overrun, validOut, dataout);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      nvec++;
      if (overrun !== 1'b0 || validOut !== 1'b1) begin
         nerr++;
         $display("FAIL bp_overrun_pulse: got o=%b v=%b want 0 1", overrun, validOut);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      nvec++;
      if (validOut !== 1'b0 || dataout !== 32'hDEAD_BEEF) begin
         nerr++;
         $display("FAIL bp_accept: got v=%b data=%h want 0 deadbeef", validOut, dataout);
      end
      // completion on the same edge as an accept
      w = 32'h1357_9BDF;
      send_bits(w, 32, 1'b0);
      w = 32'h2468_ACE0;
      send_bits(w, 31, 1'b0);
      nvec++;
      if (validOut !== 1'b1 || dataout !== 32'h1357_9BDF) begin
         nerr++;
         $display("FAIL bp_full: got v=%b data=%h want 1 13579bdf", validOut, dataout);
      end
      cycle(w[31], 1'b1, 1'b0, 1'b1);
      nvec++;
      if (validOut !== 1'b1 || overrun !== 1'b0 || dataout !== 32'h2468_ACE0) begin
         nerr++;
         $display("FAIL bp_accept_reload: got v=%b o=%b data=%h want 1 0 2468ace0", validOut, overrun, dataout);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      nvec++;
      if (validOut !== 1'b0) begin
         nerr++;
         $display("FAIL bp_drain: got %b want 0", validOut);
      end
   endtask

   task automatic test_clear;
      logic [31:0] w;
      w = 32'hFFFF_FFFF;
      send_bits(w, 10, 1'b1);
      nvec++;
      if (busy !== 1'b1) begin
         nerr++;
         $display("FAIL clear_busy_before: got %b want 1", busy);
      end
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      nvec++;
      if (busy !== 1'b0) begin
         nerr++;
         $display("FAIL clear_busy_after: got %b want 0", busy);
      end
      w = 32'h0F0F_0F0F;
      send_bits(w, 31, 1'b1);
      nvec++;
      if (validOut !== 1'b0) begin
         nerr++;
         $display("FAIL clear_early_valid: got %b want 0", validOut);
      end
      cycle(w[31], 1'b1, 1'b0, 1'b0);
      nvec++;
      if (validOut !== 1'b1 || dataout !== 32'h0F0F_0F0F) begin
         nerr++;
         $display("FAIL clear_word: got v=%b data=%h want 1 0f0f0f0f", validOut, dataout);
      end
      // clear while a word is held
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      nvec++;
      if (validOut !== 1'b1 || dataout !== 32'h0F0F_0F0F || busy !== 1'b0) begin
         nerr++;
         $display("FAIL clear_full: got v=%b data=%h b=%b want 1 0f0f0f0f 0", validOut, dataout, busy);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      nvec++;
      if (validOut !== 1'b0) begin
         nerr++;
         $display("FAIL clear_drain: got %b want 0", validOut);
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      test_reset();
      test_contiguous();
      test_gaps();
      test_back_to_back();
      test_backpressure();
      test_clear();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the 32:1 serializer. Collects a qualified LSB-first serial bit stream into WIDTH-bit parallel words and presents each completed word on a registered output with a valid/ready handshake. Flags an overrun when a word completes while the previous word is still unaccepted. Sits between a serial link (bit + bit-valid) and any word-wide consumer.

## Interface
- WIDTH, 32, word width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- datain  input  1  serial data bit.
- validIn  input  1  datain is a valid bit this cycle.
- clear  input  1  synchronous abort of the partial word.
- ready  input  1  consumer accepts dataout this cycle.
- dataout  output  WIDTH  assembled word; first received bit is dataout[0].
- validOut  output  1  dataout holds an unaccepted word.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- busy  output  1  partial word in progress (bit count ≠ 0).

## Operation
- Shift register `shreg` (WIDTH bits) and bit counter `cnt` (0..WIDTH-1, $clog2(WIDTH) bits).
- Bit capture: on each rising edge with validIn=1 and clear=0, datain enters shreg at bit position `cnt` (LSB-first); cnt increments.
- Gaps: validIn=0 holds shreg and cnt unchanged; gaps of any length inside a word are legal.
- Completion: the edge capturing bit WIDTH-1 (cnt=WIDTH-1, validIn=1) completes the word. The full word {datain, shreg[WIDTH-2:0]} goes to the output stage and cnt wraps to 0 on the same edge.
- Output stage, two states:
  - EMPTY (validOut=0): on completion -> load dataout, go FULL.
  - FULL (validOut=1): ready=1 with no completion -> EMPTY. ready=1 with completion -> load new word, stay FULL (no bubble). ready=0 with completion -> keep old dataout, drop new word, pulse overrun, stay FULL.
- dataout changes only on a load; it holds its value in EMPTY.
- clear=1: cnt<=0 and the partial word is discarded. A bit presented the same cycle (validIn=1) is also discarded. clear does not affect the output stage, so a word in FULL remains valid.
- busy = (cnt ≠ 0), driven from a register.
- Reset (rst_n=0, asynchronous, any time, including mid-word): dataout=0, validOut=0, overrun=0, busy=0, cnt=0, shreg=0, state EMPTY. The first edge after deassertion is treated as a normal cycle.

## Timing
- Latency: validOut rises in the cycle after the edge that samples the last bit. A word is accepted on an edge where validOut=1 and ready=1.
- Maximum throughput: one word per WIDTH cycles with validIn held high. With ready=1, validOut stays high for exactly one cycle per word.
- ready is ignored while validOut=0.
- overrun is high for exactly one cycle, the cycle after the dropped word's last bit. It is never asserted when ready=1 in the completion cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: hold rst_n=0 with random inputs -> dataout=0, validOut=0, overrun=0, busy=0. Assert rst_n=0 after 17 bits, release it, then send a full word -> only the new word appears.
- Contiguous: send 0xA5A53C0F LSB-first with validIn=1 for 32 cycles, ready=1 -> validOut=1 for one cycle, one cycle after bit 31, with dataout=0xA5A53C0F. busy=1 during bits 1..31.
- Gaps: send 0x12345678 with validIn toggling 1,0,0,1,... -> same single word 0x12345678, and validOut stays low until bit 31 is captured.
- Back-to-back with ready=1: send 0xFFFFFFFF then 0x00000001 continuously -> two one-cycle validOut pulses 32 cycles apart with the correct values, and overrun=0.
- Backpressure: ready=0, send 0xDEADBEEF then 0xCAFEF00D -> dataout stays 0xDEADBEEF, and overrun pulses once after the second word's last bit. Then ready=1 for one cycle -> validOut falls. Completion in the same cycle as an accept -> new word loaded and validOut stays 1.
- Clear: send 10 bits, assert clear (with validIn=1 that cycle), then send 0x0F0F0F0F -> output is exactly 0x0F0F0F0F, and busy=0 in the cycle after clear. Assert clear while FULL -> dataout and validOut are unaffected.
